// File: rtl/iob_reg_pipe_vr.sv
// Elastic DEPTH-stage pipeline register with valid/ready handshake, clock enable,
// synchronous clear and a registered occupancy count. Empty stages collapse bubbles.
module iob_reg_pipe_vr #(
  parameter int                DATA_W  = 21,
  parameter int                DEPTH   = 2,
  parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}}
) (
  input  logic                         clk_i,
  input  logic                         cke_i,
  input  logic                         arst_n_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  input  logic [DATA_W-1:0]            in_data_i,
  output logic                         in_ready_o,
  output logic                         out_valid_o,
  output logic [DATA_W-1:0]            out_data_o,
  input  logic                         out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int LVL_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  r_v;
  logic [DATA_W-1:0] r_d [DEPTH];
  logic [LVL_W-1:0]  r_level;

  logic              w_go;
  logic              w_accept;
  logic              w_emit;
  logic [DEPTH-1:0]  w_en;
  logic [DEPTH-1:0]  w_src_v;
  logic [DATA_W-1:0] w_src_d [DEPTH];

  assign w_go = cke_i & ~rst_i;

  // A stage may load when it, or any stage downstream of it, is empty, or the sink takes a word.
  always_comb begin : stage_enables
    logic v_full;
    v_full = 1'b1;
    w_en   = {DEPTH{1'b0}};
    for (int k = DEPTH-1; k >= 0; k--) begin
      v_full  = v_full & r_v[k];
      w_en[k] = w_go & (out_ready_i | ~v_full);
    end
  end

  // Source of each stage: the upstream port for stage 0, the preceding stage otherwise.
  always_comb begin : stage_sources
    w_src_v    = {DEPTH{1'b0}};
    w_src_v[0] = in_valid_i;
    w_src_d[0] = in_data_i;
    for (int k = 1; k < DEPTH; k++) begin
      w_src_v[k] = r_v[k-1];
      w_src_d[k] = r_d[k-1];
    end
  end

  assign in_ready_o  = w_en[0];
  assign out_valid_o = r_v[DEPTH-1] & ~rst_i;
  assign out_data_o  = r_d[DEPTH-1];
  assign level_o     = r_level;
  assign w_accept    = in_valid_i & w_en[0];
  assign w_emit      = out_valid_o & out_ready_i & cke_i;

  // Stage valid/data registers; a bubble advances without overwriting held data.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_v <= {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) r_d[k] <= RST_VAL;
    end else if (cke_i && rst_i) begin
      r_v <= {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) r_d[k] <= RST_VAL;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_en[k]) begin
          r_v[k] <= w_src_v[k];
          if (w_src_v[k]) r_d[k] <= w_src_d[k];
        end
      end
    end
  end

  // Occupancy counter tracks accepted minus emitted words.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_level <= {LVL_W{1'b0}};
    end else if (cke_i) begin
      if (rst_i) r_level <= {LVL_W{1'b0}};
      else       r_level <= r_level + LVL_W'(w_accept) - LVL_W'(w_emit);
    end else begin
      r_level <= r_level;
    end
  end

endmodule

// File: tb/tb_iob_reg_pipe_vr.sv
// Randomized bench for iob_reg_pipe_vr at DEPTH=3 and DEPTH=1, checked against a
// word-queue reference model where each word advances toward the output as far as it can.
module tb_iob_reg_pipe_vr;
  localparam int DW = 21;

  logic          clk = 1'b0;
  logic          cke, arst_n, rst, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          rdy3, ov3, rdy1, ov1;
  logic [DW-1:0] od3, od1;
  logic [1:0]    lvl3;
  logic [0:0]    lvl1;

  always #5 clk = ~clk;

  iob_reg_pipe_vr #(.DATA_W(DW), .DEPTH(3)) u_d3 (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .rst_i(rst),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(rdy3),
    .out_valid_o(ov3), .out_data_o(od3), .out_ready_i(out_ready), .level_o(lvl3));

  iob_reg_pipe_vr #(.DATA_W(DW), .DEPTH(1)) u_d1 (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .rst_i(rst),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(rdy1),
    .out_valid_o(ov1), .out_data_o(od1), .out_ready_i(out_ready), .level_o(lvl1));

  int n_chk  = 0;
  int n_fail = 0;

  // Per instance: queued words (oldest first) and their stage position, plus last-stage data.
  logic [DW-1:0] qd [2][$];
  int            qp [2][$];
  logic [DW-1:0] last_out [2];
  int            dep [2] = '{3, 1};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_out_valid(input int i);
    return (qd[i].size() > 0) && (qp[i][0] == dep[i] - 1) && !rst;
  endfunction

  function automatic logic exp_in_ready(input int i);
    return cke && !rst && (out_ready || (qd[i].size() < dep[i]));
  endfunction

  task automatic check_outputs(input int i, input logic rdy, input logic ov,
                               input logic [DW-1:0] od, input int lvl);
    check_eq($sformatf("in_ready_d%0d", dep[i]),  {31'd0, rdy}, {31'd0, exp_in_ready(i)});
    check_eq($sformatf("out_valid_d%0d", dep[i]), {31'd0, ov},  {31'd0, exp_out_valid(i)});
    check_eq($sformatf("out_data_d%0d", dep[i]),  {11'd0, od},  {11'd0, last_out[i]});
    check_eq($sformatf("level_d%0d", dep[i]),     lvl,          qd[i].size());
  endtask

  task automatic model_clear(input int i);
    qd[i].delete();
    qp[i].delete();
    last_out[i] = '0;
  endtask

  task automatic model_edge(input int i);
    logic emit, acc;
    int   lim, np;
    if (!cke) begin
      lim = 0;
    end else if (rst) begin
      model_clear(i);
    end else begin
      emit = exp_out_valid(i) && out_ready;
      acc  = in_valid && exp_in_ready(i);
      if (emit) begin
        void'(qd[i].pop_front());
        void'(qp[i].pop_front());
      end
      lim = dep[i];
      for (int j = 0; j < qp[i].size(); j++) begin
        np = qp[i][j] + 1;
        if (np > lim - 1) np = lim - 1;
        qp[i][j] = np;
        lim = np;
      end
      if (acc) begin
        check_eq($sformatf("model_room_d%0d", dep[i]), (lim >= 1) ? 32'd1 : 32'd0, 32'd1);
        qd[i].push_back(in_data);
        qp[i].push_back(0);
      end
      if (qd[i].size() > 0 && qp[i][0] == dep[i] - 1) last_out[i] = qd[i][0];
    end
  endtask

  task automatic check_all();
    check_outputs(0, rdy3, ov3, od3, int'(lvl3));
    check_outputs(1, rdy1, ov1, od1, int'(lvl1));
  endtask

  // Phase knobs (percent): valid, ready, cke, rst.
  int pv [5] = '{100, 100,  60,  90, 100};
  int pr [5] = '{100,   0,  50,  20,  70};
  int pc [5] = '{100, 100,  85,  95, 100};
  int ps [5] = '{  0,   0,   4,   2,   1};

  initial begin
    int ph;
    cke = 1'b1; rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; arst_n = 1'b0;
    for (int i = 0; i < 2; i++) model_clear(i);
    #2;
    check_all();
    @(negedge clk);
    arst_n = 1'b1;

    for (int c = 0; c < 2500; c++) begin
      ph = c / 500;
      @(negedge clk);
      arst_n    = 1'b1;
      in_valid  = ($urandom_range(99) < pv[ph]);
      out_ready = ($urandom_range(99) < pr[ph]);
      cke       = ($urandom_range(99) < pc[ph]);
      rst       = ($urandom_range(99) < ps[ph]);
      in_data   = DW'($urandom);
      #1;
      check_all();
      if (c % 401 == 200) begin
        // Asynchronous reset mid-cycle: outputs must clear before the next edge.
        arst_n = 1'b0;
        for (int i = 0; i < 2; i++) model_clear(i);
        #1;
        check_all();
        @(posedge clk);
      end else begin
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
